// File: rtl/generic_mul_pipe.sv
// -----------------------------------------------------------------------------
// generic_mul_pipe
//   Multi-lane, pipelined GF(2^N) multiplier with valid/ready flow control.
//   Each beat carries an op (MUL, SQR, MAC, reserved = MUL) that applies to all
//   lanes. Products are formed on entry and carried through STAGES register
//   slots. The accumulator is XORed in at the output, so back-to-back MAC beats
//   see the value committed by the previous beat's handshake.
//
//   Field per lane:
//     BIT_WIDTH=1 : GF(2), c = a & b
//     BIT_WIDTH=2 : GF(4), polynomial basis mod x^2+x+1
//     BIT_WIDTH=4 : GF(16) as a tower over GF(4), y^2 = y + phi, phi = 2'b10
//
// Ports:
//   in_clock      clock, rising edge
//   in_reset_n    asynchronous active-low reset
//   in_valid      input beat valid
//   out_in_ready  block accepts a beat this cycle
//   in_op         00 MUL, 01 SQR, 10 MAC, 11 reserved (MUL)
//   in_acc_clr    MAC only: use zero instead of the accumulator
//   in_a, in_b    operands, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   out_valid     result beat valid
//   in_out_ready  downstream accepts the result
//   out_c         result, same lane packing as the operands
// -----------------------------------------------------------------------------
module generic_mul_pipe #(
    parameter int BIT_WIDTH = 4,
    parameter int LANES     = 4,
    parameter int STAGES    = 2
) (
    input  logic                       in_clock,
    input  logic                       in_reset_n,
    input  logic                       in_valid,
    output logic                       out_in_ready,
    input  logic [1:0]                 in_op,
    input  logic                       in_acc_clr,
    input  logic [LANES*BIT_WIDTH-1:0] in_a,
    input  logic [LANES*BIT_WIDTH-1:0] in_b,
    output logic                       out_valid,
    input  logic                       in_out_ready,
    output logic [LANES*BIT_WIDTH-1:0] out_c
);

    localparam int DW   = LANES * BIT_WIDTH;
    localparam int LAST = STAGES - 1;

    // MUL (2'b00) and reserved (2'b11) need no decode: anything not SQR uses
    // in_b, anything not MAC ignores the accumulator.
    localparam logic [1:0] OP_SQR = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;

    generate
        if (!(BIT_WIDTH == 1 || BIT_WIDTH == 2 || BIT_WIDTH == 4)) begin : g_bad_width
            $error("generic_mul_pipe: BIT_WIDTH must be 1, 2 or 4");
        end
        if (LANES < 1 || LANES > 16) begin : g_bad_lanes
            $error("generic_mul_pipe: LANES must be in 1..16");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("generic_mul_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // GF(4) product, polynomial basis mod x^2+x+1.
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = a[1] & b[1];
        return {t ^ (a[1] & b[0]) ^ (a[0] & b[1]), t ^ (a[0] & b[0])};
    endfunction

    // GF(16) product in the tower representation {ah, al}.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul(hh, 2'b10) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    // Operands are widened to 4 bits so every branch is legal for every width.
    function automatic logic [BIT_WIDTH-1:0] lane_mul(input logic [BIT_WIDTH-1:0] a,
                                                      input logic [BIT_WIDTH-1:0] b);
        logic [3:0] a4, b4, r;
        a4 = 4'(a);
        b4 = 4'(b);
        case (BIT_WIDTH)
            1:       r = {3'b000, a4[0] & b4[0]};
            2:       r = {2'b00, gf4_mul(a4[1:0], b4[1:0])};
            default: r = gf16_mul(a4, b4);
        endcase
        return r[BIT_WIDTH-1:0];
    endfunction

    // Pipeline slots: index 0 is loaded from the input, LAST drives the output.
    logic          slot_valid [STAGES];
    logic [1:0]    slot_op    [STAGES];
    logic          slot_clr   [STAGES];
    logic [DW-1:0] slot_prod  [STAGES];

    logic [DW-1:0] acc;
    logic [DW-1:0] b_eff;
    logic [DW-1:0] prod;
    logic [DW-1:0] acc_term;
    logic          adv;

    // A single advance enable moves every slot together; bubbles are kept so
    // latency is always STAGES advancing cycles.
    assign out_valid    = slot_valid[LAST];
    assign adv          = in_out_ready | ~out_valid;
    assign out_in_ready = adv;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        b_eff = (in_op == OP_SQR) ? in_a : in_b;
        prod  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i*BIT_WIDTH +: BIT_WIDTH] = lane_mul(in_a[i*BIT_WIDTH +: BIT_WIDTH],
                                                      b_eff[i*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    // NOTE: state is updated with non-blocking assignments so slot i reads the
    // pre-edge contents of slot i-1.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            // NOTE: slot data is reset too, not just the valid bits, so out_c
            // reads zero straight out of reset.
            for (int i = 0; i < STAGES; i++) begin
                slot_valid[i] <= 1'b0;
                slot_op[i]    <= 2'b00;
                slot_clr[i]   <= 1'b0;
                slot_prod[i]  <= '0;
            end
        end else if (adv) begin
            slot_valid[0] <= in_valid;
            slot_op[0]    <= in_op;
            slot_clr[0]   <= in_acc_clr;
            slot_prod[0]  <= prod;
            for (int i = 1; i < STAGES; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_op[i]    <= slot_op[i-1];
                slot_clr[i]   <= slot_clr[i-1];
                slot_prod[i]  <= slot_prod[i-1];
            end
        end
    end

    // Accumulator is folded in at the output; out_c is forced to zero when the
    // last slot holds no beat.
    always_comb begin
        acc_term = '0;
        if (slot_op[LAST] == OP_MAC && !slot_clr[LAST]) begin
            acc_term = acc;
        end
        out_c = slot_valid[LAST] ? (slot_prod[LAST] ^ acc_term) : '0;
    end

    // Commit only on an output handshake of a MAC beat, so a stalled beat
    // cannot feed its own result back into itself.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            acc <= '0;
        end else if (out_valid && in_out_ready && slot_op[LAST] == OP_MAC) begin
            acc <= out_c;
        end
    end

endmodule

// File: doc/generic_mul_pipe.md
Name: generic_mul_pipe

Overview:
- Multi-lane, pipelined GF(2^N) multiplier with a valid/ready handshake. Successor to the combinational tower-field multiplier.
- Adds three things: LANES parallel lanes, STAGES-deep registered pipeline with backpressure, and per-beat op mode (multiply, square, multiply-accumulate).
- Sits between S-box inversion datapaths and any wide GF arithmetic that needs throughput-1 multiplication with flow control.

Parameters:
BIT_WIDTH, 4, field width per lane; legal values 1, 2, 4; any other value fails elaboration with $error.
LANES, 4, number of independent multiplier lanes; legal range 1..16.
STAGES, 2, pipeline register depth (latency in cycles); legal range 1..4.

Ports:
in_clock  input  1  clock; all state updates on the rising edge.
in_reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
out_in_ready  output  1  block accepts a beat this cycle.
in_op  input  2  00 MUL, 01 SQR, 10 MAC, 11 reserved (treated as MUL).
in_acc_clr  input  1  MAC only: use zero instead of the accumulator for this beat.
in_a  input  LANES*BIT_WIDTH  operand A; lane i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
in_b  input  LANES*BIT_WIDTH  operand B; ignored for SQR.
out_valid  output  1  result beat valid.
in_out_ready  input  1  downstream accepts the result.
out_c  output  LANES*BIT_WIDTH  result, same lane packing as the operands.

Behaviour:
- Field arithmetic per lane:
  - W=1: c = a & b.
  - W=2: polynomial basis mod x^2+x+1, with a = {a1,a0}.
    - c1 = a1b1 ^ a1b0 ^ a0b1
    - c0 = a1b1 ^ a0b0
  - W=4: tower over GF(4), y^2 = y + phi, phi = 2'b10, a = {ah,al}.
    - ch = ah*bh ^ ah*bl ^ al*bh
    - cl = (ah*bh)*phi ^ al*bl
    - All products here are GF(4) products.
- Op modes:
  - SQR: computes a*a.
  - MAC: per-lane result = a*b XOR acc_i, where acc_i is 0 if in_acc_clr was set with that beat.
- Pipeline: STAGES register slots, each holding a valid bit, op, clr flag, and the lane data. Implementer chooses where combinational logic is split; the result must be identical for any STAGES value.
- Flow control:
  - Global advance enable: adv = in_out_ready | ~out_valid. out_in_ready = adv (combinational).
  - A beat is accepted when in_valid & out_in_ready. When adv = 0, every slot holds.
  - Bubbles are not collapsed: latency is exactly STAGES advancing cycles.
  - At full throughput (in_out_ready held high), one beat per cycle; output appears STAGES cycles after acceptance.
- out_valid/out_c are driven from the last slot. out_c holds stable while out_valid & ~in_out_ready.
- Accumulator:
  - LANES x BIT_WIDTH register, added in the final stage.
  - Updated to out_c only on output handshake (out_valid & in_out_ready) of a MAC beat. MUL and SQR beats never touch it.
  - Because it is read in the final stage at handshake time, back-to-back MAC beats chain correctly with no hazard.
- Reset (asynchronous, any time, including mid-stream):
  - All slot valid bits, data, and the accumulator go to 0.
  - out_valid = 0, out_c = 0; out_in_ready = 1 while reset is deasserted and the pipe is empty.
  - In-flight beats are discarded.
- Simultaneous handshakes: input accept and output accept in the same cycle are legal at full rate.
- Reserved op 11 behaves exactly as MUL, including no accumulator update.

Test Plan:
- W=2, LANES=1, STAGES=1: MUL a=2'b10, b=2'b10 -> out_c=2'b11 one cycle after accept; exhaustive 16-pair sweep matches the formula.
- W=4, LANES=4, STAGES=2: MUL lane0 4'h4*4'h4 -> 4'h6; lane1 4'h1*4'hB -> 4'hB; lane2 0*x -> 0; SQR lane3 a=4'h4 -> 4'h6; out_valid exactly 2 cycles after accept.
- MAC chain, W=4, LANES=1: beats (4'h1,4'h3,clr=1), (4'h1,4'h5,clr=0), (4'h4,4'h4,clr=0) -> out_c = 4'h3, 4'h6, 4'h0; the intervening MUL beat leaves acc unchanged.
- Backpressure: stream 8 random beats with in_out_ready toggling at a random ~50% duty -> no loss or duplication, order preserved, out_c stable while stalled, out_in_ready=0 exactly when out_valid & ~in_out_ready.
- Reset mid-stream with STAGES=3 and the pipe full: assert in_reset_n=0 asynchronously between clock edges -> out_valid=0 and out_c=0 immediately, acc=0; the first MAC after release without clr returns the plain product.
- Full throughput with in_out_ready=1 and 100 back-to-back beats -> 100 results on consecutive cycles, matching a reference model; W=1 build gives a&b.
